// File: rtl/imem_loader.sv
// Byte-stream loader that assembles big-endian 32-bit instruction words and writes them to imem.
// Latency: wr_en rises the cycle after the 4th byte handshake; done one cycle after the last write.
// Backpressure: byte_ready is high only in RECV; byte_valid=0 cycles simply stall assembly.
//
// Ports:
//   clk, reset           : rising-edge clock, asynchronous active-high reset
//   start, word_count    : load request and word count (both sampled only in IDLE)
//   byte_in/valid/ready  : byte stream handshake, accepted when valid & ready
//   wr_en/addr/data      : instruction-memory write port (byte address, word aligned)
//   cpu_hold             : holds the CPU while a load is in progress
//   done, err            : one-cycle completion / rejected-start pulses
module imem_loader #(
  parameter int DEPTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] word_count,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             wr_en,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wr_data,
  output logic             cpu_hold,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_t           state_q,    state_d;
  logic [CNT_W-1:0] count_q,    count_d;
  logic [CNT_W-1:0] index_q,    index_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [31:0]      shift_q,    shift_d;
  logic             err_q,      err_d;

  logic [CNT_W-1:0] index_inc;
  logic [31:0]      index_addr;

  assign index_inc = index_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    index_d    = index_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (word_count > DEPTH_C) begin
            err_d = 1'b1;
          end else if (word_count == '0) begin
            state_d = FIN;
          end else begin
            count_d    = word_count;
            index_d    = '0;
            byte_cnt_d = '0;
            state_d    = RECV;
          end
        end
      end
      RECV: begin
        if (byte_valid) begin
          shift_d    = {shift_q[23:0], byte_in};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        byte_cnt_d = '0;
        if (index_inc == count_q) begin
          // Last word: park the index at 0 rather than stepping to DEPTH,
          // so it never leaves the valid 0..DEPTH-1 range.
          index_d = '0;
          state_d = FIN;
        end else begin
          index_d = index_inc;
          state_d = RECV;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      index_q    <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      index_q    <= index_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      err_q      <= err_d;
    end
  end

  // Word index to byte address: {index, 2'b00}, zero-extended.
  always_comb begin
    index_addr                = '0;
    index_addr[CNT_W+1:2]     = index_q;
  end

  // Outputs are decoded from registered state only.
  assign byte_ready = (state_q == RECV);
  assign wr_en      = (state_q == WRITE);
  assign wr_addr    = wr_en ? index_addr : 32'd0;
  assign wr_data    = wr_en ? shift_q : 32'd0;
  assign cpu_hold   = (state_q != IDLE);
  assign done       = (state_q == FIN);
  assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: word assembly, stalls, count boundaries, reset, ignored start.
module tb_imem_loader;

  localparam int DEPTH = 64;
  localparam int CNT_W = 7;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] word_count = '0;
  logic [7:0]       byte_in = '0;
  logic             byte_valid = 1'b0;
  logic             byte_ready;
  logic             wr_en;
  logic [31:0]      wr_addr;
  logic [31:0]      wr_data;
  logic             cpu_hold;
  logic             done;
  logic             err;

  int n_checks = 0;
  int n_errors = 0;

  // Event counters sampled on the falling edge.
  int wr_seen   = 0;
  int done_seen = 0;
  int err_seen  = 0;
  int idle_junk = 0;

  imem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en)   wr_seen++;
    if (done)    done_seen++;
    if (err)     err_seen++;
    if (!wr_en && (wr_addr != 32'd0 || wr_data != 32'd0)) idle_junk++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdy"},  {31'd0, byte_ready}, 32'd0);
    check({tag, "_wren"}, {31'd0, wr_en},      32'd0);
    check({tag, "_addr"}, wr_addr,             32'd0);
    check({tag, "_data"}, wr_data,             32'd0);
    check({tag, "_hold"}, {31'd0, cpu_hold},   32'd0);
    check({tag, "_done"}, {31'd0, done},       32'd0);
    check({tag, "_err"},  {31'd0, err},        32'd0);
  endtask

  task automatic do_start(input logic [CNT_W-1:0] cnt);
    start      = 1'b1;
    word_count = cnt;
    tick();
    start      = 1'b0;
  endtask

  // Offer one byte, optionally after some valid-low stall cycles; returns after the handshake edge.
  task automatic send_byte(input logic [7:0] b, input int stalls);
    int n;
    for (int i = 0; i < stalls; i++) begin
      byte_valid = 1'b0;
      tick();
    end
    byte_in    = b;
    byte_valid = 1'b1;
    n = 0;
    while (!byte_ready && n < 20) begin
      tick();
      n++;
    end
    if (!byte_ready) check("rdy_timeout", {31'd0, byte_ready}, 32'd1);
    tick();
  endtask

  // Send four bytes MSB first, then check the write cycle that must follow immediately.
  task automatic send_word(input string tag, input logic [31:0] w, input logic [31:0] addr, input int stalls);
    send_byte(w[31:24], stalls);
    send_byte(w[23:16], stalls);
    send_byte(w[15:8],  stalls);
    send_byte(w[7:0],   stalls);
    check({tag, "_wren"}, {31'd0, wr_en},      32'd1);
    check({tag, "_addr"}, wr_addr,             addr);
    check({tag, "_data"}, wr_data,             w);
    check({tag, "_rdy"},  {31'd0, byte_ready}, 32'd0);
    check({tag, "_hold"}, {31'd0, cpu_hold},   32'd1);
  endtask

  task automatic expect_fin(input string tag);
    check({tag, "_done"}, {31'd0, done},     32'd1);
    check({tag, "_hold"}, {31'd0, cpu_hold}, 32'd1);
    check({tag, "_wren"}, {31'd0, wr_en},    32'd0);
    tick();
    check({tag, "_done_off"}, {31'd0, done},     32'd0);
    check({tag, "_hold_off"}, {31'd0, cpu_hold}, 32'd0);
  endtask

  task automatic two_word_load(input string tag, input int stalls);
    int w0;
    w0 = wr_seen;
    do_start(7'd2);
    check({tag, "_rdy_start"}, {31'd0, byte_ready}, 32'd1);
    check({tag, "_hold_start"}, {31'd0, cpu_hold},  32'd1);
    send_word({tag, "_w0"}, 32'h2008_0020, 32'h00, stalls);
    tick();
    check({tag, "_hold_mid"}, {31'd0, cpu_hold}, 32'd1);
    send_word({tag, "_w1"}, 32'h2009_0037, 32'h04, stalls);
    byte_valid = 1'b0;
    tick();
    expect_fin(tag);
    check({tag, "_nwr"}, wr_seen - w0, 2);
  endtask

  initial begin
    int w0, d0, e0;
    logic [31:0] w;

    // Reset state
    #2 reset = 1'b1;
    #2;
    check_all_zero("rst");
    tick();
    #2 reset = 1'b0;
    tick();
    check_all_zero("post_rst");

    // Two words, byte_valid held high
    two_word_load("load2", 0);

    // Same load with byte_valid low on alternate cycles
    two_word_load("stall2", 1);

    // word_count = 0
    w0 = wr_seen;
    do_start(7'd0);
    expect_fin("cnt0");
    check("cnt0_nwr", wr_seen - w0, 0);

    // word_count = DEPTH+1 is rejected
    w0 = wr_seen; e0 = err_seen;
    do_start(7'd65);
    check("cnt65_err",  {31'd0, err},        32'd1);
    check("cnt65_hold", {31'd0, cpu_hold},   32'd0);
    check("cnt65_rdy",  {31'd0, byte_ready}, 32'd0);
    tick();
    check("cnt65_err_off", {31'd0, err}, 32'd0);
    check("cnt65_nerr", err_seen - e0, 1);
    check("cnt65_nwr",  wr_seen - w0, 0);

    // word_count = DEPTH fills memory up to 0xFC
    w0 = wr_seen;
    do_start(7'd64);
    for (int i = 0; i < DEPTH; i++) begin
      w = {i[7:0], ~i[7:0], 8'h5A, i[7:0] ^ 8'hC3};
      send_word("full", w, 32'(i) << 2, 0);
      if (i == DEPTH - 1) check("full_last_addr", wr_addr, 32'h0000_00FC);
      tick();
    end
    byte_valid = 1'b0;
    expect_fin("full");
    check("full_nwr", wr_seen - w0, 64);

    // Reset mid-word, then a clean single-word load
    do_start(7'd1);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    byte_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_all_zero("midrst");
    tick();
    #2 reset = 1'b0;
    tick();
    w0 = wr_seen;
    do_start(7'd1);
    send_word("after_rst", 32'h8C11_0004, 32'h00, 0);
    byte_valid = 1'b0;
    tick();
    expect_fin("after_rst");
    check("after_rst_nwr", wr_seen - w0, 1);

    // start with a new count during a load is ignored
    w0 = wr_seen; d0 = done_seen; e0 = err_seen;
    do_start(7'd1);
    start      = 1'b1;
    word_count = 7'd5;
    send_word("restart", 32'h1234_5678, 32'h00, 0);
    start      = 1'b0;
    byte_valid = 1'b0;
    tick();
    expect_fin("restart");
    tick();
    tick();
    check("restart_hold_idle", {31'd0, cpu_hold}, 32'd0);
    check("restart_nwr",  wr_seen - w0,   1);
    check("restart_ndone", done_seen - d0, 1);
    check("restart_nerr", err_seen - e0,  0);

    check("idle_outputs_zero", idle_junk, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
